// File: rtl/mbinit_pkg.sv
// rtl/mbinit_pkg.sv - sideband message codes and MBINIT.REVERSALMB state encoding
package mbinit_pkg;

    localparam logic [3:0] MSG_NONE             = 4'd0;
    localparam logic [3:0] MSG_INIT_REQ         = 4'd1;
    localparam logic [3:0] MSG_INIT_RESP        = 4'd2;
    localparam logic [3:0] MSG_CLEAR_ERROR_REQ  = 4'd3;
    localparam logic [3:0] MSG_CLEAR_ERROR_RESP = 4'd4;
    localparam logic [3:0] MSG_RESULT_REQ       = 4'd5;
    localparam logic [3:0] MSG_RESULT_RESP      = 4'd6;
    localparam logic [3:0] MSG_DONE_REQ         = 4'd7;
    localparam logic [3:0] MSG_DONE_RESP        = 4'd8;

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_CHK_BUSY_INIT,   ST_SEND_INIT,   ST_WAIT_INIT,
        ST_CHK_BUSY_CLEAR,  ST_SEND_CLEAR,  ST_WAIT_CLEAR,
        ST_PATTERN,
        ST_CHK_BUSY_RESULT, ST_SEND_RESULT, ST_WAIT_RESULT,
        ST_EVALUATE,
        ST_CHK_BUSY_DONE,   ST_SEND_DONE,   ST_WAIT_DONE,
        ST_DONE,
        ST_ERROR
    } state_t;

    function automatic logic is_wait(state_t s);
        return (s == ST_WAIT_INIT) || (s == ST_WAIT_CLEAR) ||
               (s == ST_WAIT_RESULT) || (s == ST_WAIT_DONE);
    endfunction

    // Request carried by each SEND_* state; MSG_NONE everywhere else.
    function automatic logic [3:0] send_msg(state_t s);
        case (s)
            ST_SEND_INIT:   return MSG_INIT_REQ;
            ST_SEND_CLEAR:  return MSG_CLEAR_ERROR_REQ;
            ST_SEND_RESULT: return MSG_RESULT_REQ;
            ST_SEND_DONE:   return MSG_DONE_REQ;
            default:        return MSG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/reversalmb_module_if.sv
// rtl/reversalmb_module_if.sv - sideband, pattern and status signals of the REVERSALMB initiator
interface reversalmb_module_if #(parameter int NUM_LANES = 16);

    logic [3:0]           i_Rx_SbMessage;
    logic                 i_msg_valid;
    logic                 i_Busy_SideBand;
    logic                 i_falling_edge_busy;
    logic                 i_pattern_done;
    logic [NUM_LANES-1:0] i_Rx_Result_logged;
    logic [3:0]           o_TX_SbMessage;
    logic                 o_ValidOutData_Module;
    logic                 o_Pattern_Gen_En;
    logic                 o_Lane_Reversal_En;
    logic                 o_MBINIT_REVERSALMB_Module_end;
    logic                 o_MBINIT_REVERSALMB_Error;

    modport master (
        input  i_Rx_SbMessage, i_msg_valid, i_Busy_SideBand, i_falling_edge_busy,
               i_pattern_done, i_Rx_Result_logged,
        output o_TX_SbMessage, o_ValidOutData_Module, o_Pattern_Gen_En,
               o_Lane_Reversal_En, o_MBINIT_REVERSALMB_Module_end, o_MBINIT_REVERSALMB_Error
    );

    modport slave (
        output i_Rx_SbMessage, i_msg_valid, i_Busy_SideBand, i_falling_edge_busy,
               i_pattern_done, i_Rx_Result_logged,
        input  o_TX_SbMessage, o_ValidOutData_Module, o_Pattern_Gen_En,
               o_Lane_Reversal_En, o_MBINIT_REVERSALMB_Module_end, o_MBINIT_REVERSALMB_Error
    );

endinterface

// File: rtl/lane_popcount.sv
// rtl/lane_popcount.sv - combinational count of passing lanes
module lane_popcount #(
    parameter int NUM_LANES = 16,
    parameter int CW        = $clog2(NUM_LANES + 1)
) (
    input  logic [NUM_LANES-1:0] lanes_i,
    output logic [CW-1:0]        count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            count_o = count_o + CW'(lanes_i[i]);
        end
    end

endmodule

// File: rtl/reversalmb_module.sv
// rtl/reversalmb_module.sv - MBINIT.REVERSALMB initiator FSM with one lane-reversal retry
module reversalmb_module
    import mbinit_pkg::*;
#(
    parameter int NUM_LANES      = 16,
    parameter int PASS_THRESHOLD = 9,
    parameter int TIMEOUT_CYCLES = 8000,
    parameter int CNT_W          = 13
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic i_REPAIRVAL_end,
    reversalmb_module_if.master sb
);

    localparam int PW = $clog2(NUM_LANES + 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     tmo_cnt_q;
    logic [NUM_LANES-1:0] result_q;
    logic                 reversal_tried_q;
    logic [3:0]           tx_msg_q;
    logic                 tx_valid_q, pat_en_q, end_q, err_q;
    logic [PW-1:0]        pass_cnt;
    logic [3:0]           rx_msg;
    logic                 tmo_hit;

    lane_popcount #(.NUM_LANES(NUM_LANES), .CW(PW)) u_popcount (
        .lanes_i (result_q),
        .count_o (pass_cnt)
    );

    // An invalid cycle looks like "no message", so unqualified codes never match.
    assign rx_msg  = sb.i_msg_valid ? sb.i_Rx_SbMessage : MSG_NONE;
    assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:            state_d = ST_CHK_BUSY_INIT;
            ST_CHK_BUSY_INIT:   if (!sb.i_Busy_SideBand) state_d = ST_SEND_INIT;
            ST_SEND_INIT:       if (sb.i_falling_edge_busy) state_d = ST_WAIT_INIT;
            ST_WAIT_INIT:       if (rx_msg == MSG_INIT_RESP) state_d = ST_CHK_BUSY_CLEAR;
                                else if (tmo_hit) state_d = ST_ERROR;
            ST_CHK_BUSY_CLEAR:  if (!sb.i_Busy_SideBand) state_d = ST_SEND_CLEAR;
            ST_SEND_CLEAR:      if (sb.i_falling_edge_busy) state_d = ST_WAIT_CLEAR;
            ST_WAIT_CLEAR:      if (rx_msg == MSG_CLEAR_ERROR_RESP) state_d = ST_PATTERN;
                                else if (tmo_hit) state_d = ST_ERROR;
            ST_PATTERN:         if (sb.i_pattern_done) state_d = ST_CHK_BUSY_RESULT;
            ST_CHK_BUSY_RESULT: if (!sb.i_Busy_SideBand) state_d = ST_SEND_RESULT;
            ST_SEND_RESULT:     if (sb.i_falling_edge_busy) state_d = ST_WAIT_RESULT;
            ST_WAIT_RESULT:     if (rx_msg == MSG_RESULT_RESP) state_d = ST_EVALUATE;
                                else if (tmo_hit) state_d = ST_ERROR;
            ST_EVALUATE: begin
                if (pass_cnt >= PW'(PASS_THRESHOLD)) state_d = ST_CHK_BUSY_DONE;
                else if (!reversal_tried_q)          state_d = ST_CHK_BUSY_CLEAR;
                else                                 state_d = ST_ERROR;
            end
            ST_CHK_BUSY_DONE:   if (!sb.i_Busy_SideBand) state_d = ST_SEND_DONE;
            ST_SEND_DONE:       if (sb.i_falling_edge_busy) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE:       if (rx_msg == MSG_DONE_RESP) state_d = ST_DONE;
                                else if (tmo_hit) state_d = ST_ERROR;
            ST_DONE:            state_d = ST_DONE;
            ST_ERROR:           state_d = ST_ERROR;
            default:            state_d = ST_IDLE;
        endcase
        if (!i_REPAIRVAL_end) state_d = ST_IDLE;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            tmo_cnt_q        <= '0;
            result_q         <= '0;
            reversal_tried_q <= 1'b0;
            tx_msg_q         <= MSG_NONE;
            tx_valid_q       <= 1'b0;
            pat_en_q         <= 1'b0;
            end_q            <= 1'b0;
            err_q            <= 1'b0;
        end else begin
            state_q <= state_d;
            // Restart on each WAIT_* entry; outside WAIT_* the counter rests at zero.
            if (is_wait(state_d) && (state_d != state_q)) tmo_cnt_q <= '0;
            else if (is_wait(state_d))                    tmo_cnt_q <= tmo_cnt_q + 1'b1;
            else                                          tmo_cnt_q <= '0;
            if (state_q == ST_WAIT_RESULT && rx_msg == MSG_RESULT_RESP)
                result_q <= sb.i_Rx_Result_logged;
            // The retry flag doubles as the reversal enable; only an abort clears it.
            if (state_d == ST_IDLE)
                reversal_tried_q <= 1'b0;
            else if (state_q == ST_EVALUATE && state_d == ST_CHK_BUSY_CLEAR)
                reversal_tried_q <= 1'b1;
            tx_msg_q   <= send_msg(state_d);
            tx_valid_q <= (send_msg(state_d) != MSG_NONE);
            pat_en_q   <= (state_d == ST_PATTERN);
            end_q      <= (state_d == ST_DONE);
            err_q      <= (state_d == ST_ERROR);
        end
    end

    assign sb.o_TX_SbMessage                 = tx_msg_q;
    assign sb.o_ValidOutData_Module          = tx_valid_q;
    assign sb.o_Pattern_Gen_En               = pat_en_q;
    assign sb.o_Lane_Reversal_En             = reversal_tried_q;
    assign sb.o_MBINIT_REVERSALMB_Module_end = end_q;
    assign sb.o_MBINIT_REVERSALMB_Error      = err_q;

endmodule

// File: doc/reversalmb_module.md
Name: reversalmb_module

Overview:
Initiator ("Module") side of the MBINIT.REVERSALMB sideband handshake; counterpart to the partner responder in LTSM/MBINIT.
- Sends init, clear_error, result and done requests, and waits for each response.
- Between clear_error and result, drives the per-lane pattern generator.
- Evaluates the partner's 16-bit per-lane result and, if needed, applies lane reversal and retries once.
- Runs after REPAIRVAL completes; ends with done, or error to the LTSM.

Parameters:
NUM_LANES, 16, data lanes reported in the result field
PASS_THRESHOLD, 9, minimum lanes passing (popcount) for success (>50%)
TIMEOUT_CYCLES, 8000, max cycles in any WAIT_* state before error
CNT_W, 13, timeout counter width (must hold TIMEOUT_CYCLES)

Ports:
CLK  in  1  clock
rst_n  in  1  async active-low reset
i_REPAIRVAL_end  in  1  enable; low aborts to IDLE
i_Rx_SbMessage  in  4  decoded received sideband message
i_msg_valid  in  1  i_Rx_SbMessage valid this cycle
i_Busy_SideBand  in  1  sideband TX busy
i_falling_edge_busy  in  1  one-cycle pulse, TX finished a message
i_pattern_done  in  1  pattern generator finished burst (pulse)
i_Rx_Result_logged  in  NUM_LANES  per-lane pass bits from result_resp data field
o_TX_SbMessage  out  4  message to transmit
o_ValidOutData_Module  out  1  o_TX_SbMessage valid
o_Pattern_Gen_En  out  1  run per-lane ID pattern
o_Lane_Reversal_En  out  1  apply lane reversal in TX/RX mapping
o_MBINIT_REVERSALMB_Module_end  out  1  sequence passed
o_MBINIT_REVERSALMB_Error  out  1  trainerror request

Behaviour:
Reset and message encoding:
- Reset, asynchronous: all outputs 0; state IDLE; reversal_tried 0; timeout counter 0.
- Message encodings: init_req 1, init_resp 2, clear_error_req 3, clear_error_resp 4, result_req 5, result_resp 6, done_req 7, done_resp 8.

Output timing:
- Two-process FSM; outputs are registered, decoded from NS, so each output is valid the cycle the state is entered.

State sequence (any state with i_REPAIRVAL_end=0 goes to IDLE next cycle):
- IDLE -> CHK_BUSY_INIT when enabled.
- CHK_BUSY_INIT -> SEND_INIT when !i_Busy_SideBand.
- SEND_INIT drives msg=1, valid=1 -> WAIT_INIT on i_falling_edge_busy.
- WAIT_INIT: valid=0 -> CHK_BUSY_CLEAR on msg_valid && msg==2.
- CHK_BUSY_CLEAR -> SEND_CLEAR (msg=3) -> WAIT_CLEAR. On msg==4 -> PATTERN.
- PATTERN: o_Pattern_Gen_En=1 until i_pattern_done -> CHK_BUSY_RESULT.
- CHK_BUSY_RESULT -> SEND_RESULT (msg=5) -> WAIT_RESULT. On msg==6, latch i_Rx_Result_logged same cycle -> EVALUATE.
- EVALUATE (1 cycle), using popcount(latched):
  - popcount >= PASS_THRESHOLD -> CHK_BUSY_DONE.
  - else if !reversal_tried: set reversal_tried=1, o_Lane_Reversal_En=1 -> CHK_BUSY_CLEAR (retry).
  - else -> ERROR.
- CHK_BUSY_DONE -> SEND_DONE (msg=7) -> WAIT_DONE. On msg==8 -> DONE.
- DONE: end=1 held. Lane_Reversal_En keeps its value. Leave only via enable low.
- ERROR: Error=1 held; valid=0. Leave only via enable low.

Message and timeout rules:
- Messages received outside the matching WAIT_* state are ignored.
- Messages without i_msg_valid are ignored.
- Timeout counter clears on entry to each WAIT_* state and increments every cycle there.
- Reaching TIMEOUT_CYCLES-1 -> ERROR.
- Response arriving in the same cycle as expiry: the response wins.

Abort (enable low):
- All outputs clear, including Lane_Reversal_En and reversal_tried.
- Counters clear.

Other boundary rules:
- i_falling_edge_busy while not in a SEND_* state: ignored.
- Busy stays high: remain in CHK_BUSY_* indefinitely, with no timeout.
- popcount width is $clog2(NUM_LANES+1), unsigned compare.

Decomposition:
- Shared package mbinit_pkg: sideband message localparams (1..8, shared with the partner block) and the state enum.
- One sub-module, lane_popcount (NUM_LANES in, count out, combinational), reusable by REPAIRMB.

Test Plan:
- Result 0xFFFF, no busy stalls -> msg sequence 1,3,5,7 -> end=1; Lane_Reversal_En=0; Error=0.
- Result 0x00FF (8 pass) -> reversal applied, clear_error resent. Second result 0xFFFE -> done, end=1, Lane_Reversal_En=1.
- Result 0x0001 twice -> Error=1 after second EVALUATE; no done_req is sent.
- No init_resp for TIMEOUT_CYCLES -> Error=1. Response arriving on the expiry cycle -> proceeds normally.
- i_Busy_SideBand high 20 cycles in CHK_BUSY_RESULT -> valid stays 0, then msg=5 asserts the cycle after busy drops.
- Enable dropped mid-PATTERN -> next cycle IDLE, all outputs 0. Re-enable -> fresh sequence starting with init_req.
